// File: rtl/alu_mc_if.sv
// Bundles the request/response signals of the multi-cycle ALU.
// Latency: none, wires only.
// Backpressure: requester must hold off while busy=1; start is dropped otherwise.
// Ports: start/a/b/ALUControl from master; result, zero/negative/carry/overflow, busy, done from slave.
interface alu_mc_if #(
   parameter int N = 64
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [3:0]   ALUControl;
   logic [N-1:0] result;
   logic         zero;
   logic         negative;
   logic         carry;
   logic         overflow;
   logic         busy;
   logic         done;

   modport master (
      output start, a, b, ALUControl,
      input  result, zero, negative, carry, overflow, busy, done
   );

   modport slave (
      input  start, a, b, ALUControl,
      output result, zero, negative, carry, overflow, busy, done
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle N-bit ALU: logic/add/sub/shift in one edge, shift-add unsigned MUL over N edges.
// Latency: single-cycle ops done the cycle after accept; MUL done exactly N cycles after accept.
// Backpressure: busy=1 during MUL, start ignored until busy drops (start with done=1 is accepted).
// Ports: clk, reset (async active-high), bus (alu_mc_if.slave) carrying request, result, NZCV flags, busy, done.
module alu_mc #(
   parameter int N = 64
) (
   input  logic     clk,
   input  logic     reset,
   alu_mc_if.slave  bus
);
   localparam int SW = $clog2(N);

   typedef enum logic {IDLE, MUL} state_t;

   state_t         state_q,    state_d;
   logic [N-1:0]   result_q,   result_d;
   logic           zero_q,     zero_d;
   logic           negative_q, negative_d;
   logic           carry_q,    carry_d;
   logic           overflow_q, overflow_d;
   logic           busy_q,     busy_d;
   logic           done_q,     done_d;
   logic [2*N-1:0] mcand_q,    mcand_d;
   logic [N-1:0]   mplier_q,   mplier_d;
   logic [2*N-1:0] acc_q,      acc_d;
   logic [SW-1:0]  cnt_q,      cnt_d;

   // Single-cycle datapath, evaluated straight from the request inputs.
   logic [N:0]     sum_w;
   logic [N-1:0]   alu_res;
   logic           alu_c;
   logic           alu_v;
   logic [2*N-1:0] acc_step;

   always_comb begin
      sum_w   = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      unique case (bus.ALUControl)
         4'b0000: alu_res = bus.a & bus.b;
         4'b0001: alu_res = bus.a | bus.b;
         4'b0010: begin
            sum_w   = {1'b0, bus.a} + {1'b0, bus.b};
            alu_res = sum_w[N-1:0];
            alu_c   = sum_w[N];
            alu_v   = (bus.a[N-1] == bus.b[N-1]) && (alu_res[N-1] != bus.a[N-1]);
         end
         4'b0110: begin
            // a + ~b + 1: carry-out is the "no borrow" indication
            sum_w   = {1'b0, bus.a} + {1'b0, ~bus.b} + (N+1)'(1);
            alu_res = sum_w[N-1:0];
            alu_c   = sum_w[N];
            alu_v   = (bus.a[N-1] != bus.b[N-1]) && (alu_res[N-1] != bus.a[N-1]);
         end
         4'b0111: alu_res = bus.b;
         4'b1100: alu_res = ~(bus.a | bus.b);
         4'b1001: alu_res = bus.a << bus.b[SW-1:0];
         4'b1010: alu_res = bus.a >> bus.b[SW-1:0];
         default: alu_res = '0;
      endcase
   end

   // One multiplier bit per edge, LSB first; multiplicand pre-shifted each step.
   assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      zero_d     = zero_q;
      negative_d = negative_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.ALUControl == 4'b1000) begin
                  state_d  = MUL;
                  busy_d   = 1'b1;
                  mcand_d  = {{N{1'b0}}, bus.a};
                  mplier_d = bus.b;
                  acc_d    = '0;
                  cnt_d    = '0;
               end else begin
                  result_d   = alu_res;
                  zero_d     = (alu_res == '0);
                  negative_d = alu_res[N-1];
                  carry_d    = alu_c;
                  overflow_d = alu_v;
                  done_d     = 1'b1;
               end
            end
         end
         MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SW'(1);
            if (cnt_q == {SW{1'b1}}) begin
               state_d    = IDLE;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               result_d   = acc_step[N-1:0];
               zero_d     = (acc_step[N-1:0] == '0);
               negative_d = acc_step[N-1];
               carry_d    = 1'b0;
               overflow_d = |acc_step[2*N-1:N];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         result_q   <= '0;
         zero_q     <= 1'b0;
         negative_q <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         negative_q <= negative_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.result   = result_q;
   assign bus.zero     = zero_q;
   assign bus.negative = negative_q;
   assign bus.carry    = carry_q;
   assign bus.overflow = overflow_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle LEGv8 datapath ALU.
- Adds N-bit width, full NZCV-style flags, shifts, NOR and an iterative unsigned multiplier (shift-add, one bit per cycle).
- Uses a start/busy/done handshake.
- Sits beside the execute stage. A multi-cycle control FSM drives it, and that FSM stalls while busy=1.

Parameters:
- N, 64, operand and result width in bits; must be a power of two, N >= 8.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request. Accepted on a rising clk edge when start=1 and busy=0.
- a  input  N  operand A. Latched at accept.
- b  input  N  operand B. Latched at accept.
- ALUControl  input  4  operation select. Latched at accept.
- result  output  N  registered result. Holds until the next completion.
- zero  output  1  result == 0
- negative  output  1  result[N-1]
- carry  output  1  carry or no-borrow flag (see Behaviour)
- overflow  output  1  signed overflow (ADD/SUB) or product overflow (MUL)
- busy  output  1  operation in progress; start is ignored while busy=1
- done  output  1  one-cycle pulse when result and flags are updated

Behaviour:
- Reset (async, immediate, any state):
  - FSM goes to IDLE.
  - result=0, zero=0, negative=0, carry=0, overflow=0, busy=0, done=0.
  - Any in-flight MUL is abandoned and produces no done pulse.
- FSM states: IDLE, MUL.
  - IDLE to MUL: accept with ALUControl=1000.
  - MUL to IDLE: after the N-th iteration.
  - Every other accepted op completes from IDLE in one edge and stays in IDLE.
- ALUControl encodings:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (a-b)
  - 0111 pass b
  - 1100 NOR
  - 1001 LSL (a << b[log2N-1:0])
  - 1010 LSR (a >> b[log2N-1:0], logical)
  - 1000 MUL (low N bits of unsigned a*b)
  - Any other code: result=0 and flags computed normally, so zero=1 and the rest are 0.
- Single-cycle ops:
  - Accept at edge k. result and flags are registered at edge k.
  - done=1 for the cycle following edge k. busy stays 0.
- MUL:
  - At accept: busy=1, multiplicand and multiplier latched, 2N-bit accumulator cleared, iteration counter = 0.
  - Each subsequent edge processes one multiplier bit, LSB first.
  - At edge k+N: result=product[N-1:0], flags updated, busy=0, done=1 for the following cycle.
  - Latency is exactly N cycles from accept to done.
  - Outputs result/flags keep their previous values while busy=1.
- Flags:
  - zero and negative are derived from the new result for every op.
  - ADD: carry = bit N of the (N+1)-bit sum. overflow = operands have the same sign and the result sign differs.
  - SUB: computed as a + ~b + 1. carry = 1 when no borrow (a >= b unsigned). overflow = operands have different signs and the result sign differs from a.
  - MUL: carry=0. overflow=1 if product[2N-1:N] != 0.
  - All other ops: carry=0, overflow=0.
- Width/arithmetic:
  - All arithmetic is modulo 2^N; wrap-around is not an error.
  - Shift amount uses only the low log2(N) bits of b, so shift N is treated as shift 0.
- Boundary conditions:
  - start while busy=1: ignored. Operands, op and the in-flight MUL are unaffected, and no extra done is produced.
  - start=1 in the same cycle done=1: accepted, because busy=0. This gives back-to-back single-cycle ops one per clock with done high every cycle.
  - a/b/ALUControl changing while busy: no effect.
  - Reset asserted mid-MUL: outputs clear immediately. The next start after reset release is accepted normally.

Test Plan:
- N=64, a=2, b=1, ops AND/OR/ADD/SUB/pass-b/NOR issued back-to-back:
  - results 0, 3, 3, 1, 1, 0xFFFF_FFFF_FFFF_FFFC
  - done high on each of 6 consecutive cycles; busy never rises.
- ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, zero=1, carry=1, overflow=0.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, negative=1, overflow=1, carry=0.
- SUB a=1, b=2 -> result=0xFFFF_FFFF_FFFF_FFFF, negative=1, carry=0.
- SUB a=2, b=1 -> result=1, carry=1.
- MUL a=3, b=5 -> busy high for exactly 64 cycles, single done pulse, result=15, overflow=0.
- MUL a=0x8000_0000_0000_0000, b=2 -> result=0, zero=1, overflow=1.
- start pulsed at cycle 10 of a MUL with different operands -> ignored; original product returned at cycle 64.
- reset asserted at cycle 30 of a MUL -> all outputs 0 immediately and no done.
- LSL a=1, b=65 -> result=2 (shift amount 1).
- LSR a=0x8000_0000_0000_0000, b=63 -> result=1.
- Unknown code 1111 -> result=0, zero=1.
